// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with occupancy level, threshold flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read_data.
module sync_fifo #(
    parameter int DATA_WIDTH         = 4,
    parameter int ADDRESS_WIDTH      = 5,
    parameter int ALMOST_FULL_LEVEL  = 28,
    parameter int ALMOST_EMPTY_LEVEL = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic                   write_increment,
    input  logic                   read_increment,
    input  logic                   clear_errors,
    output logic [DATA_WIDTH-1:0]  read_data,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [ADDRESS_WIDTH:0] level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    localparam logic [ADDRESS_WIDTH:0] DEPTH_L =
        (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0] AF_L =
        (ADDRESS_WIDTH+1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDRESS_WIDTH:0] AE_L =
        (ADDRESS_WIDTH+1)'(ALMOST_EMPTY_LEVEL);
    localparam logic [ADDRESS_WIDTH:0] LVL_ONE =
        (ADDRESS_WIDTH+1)'(1);
    localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE =
        ADDRESS_WIDTH'(1);

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic [ADDRESS_WIDTH:0]   level_q;
    logic                     wr_acc;
    logic                     rd_acc;
    logic                     wr_rej;
    logic                     rd_rej;

    // Flags are pure decodes of the registered level.
    assign level        = level_q;
    assign empty        = (level_q == '0);
    assign full         = (level_q == DEPTH_L);
    assign almost_empty = (level_q <= AE_L);
    assign almost_full  = (level_q >= AF_L);

    assign wr_acc = write_increment && !full;
    assign rd_acc = read_increment && !empty;
    assign wr_rej = write_increment && full;
    assign rd_rej = read_increment && empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc)
                rd_ptr <= rd_ptr + PTR_ONE;

            unique case (1'b1)
                wr_acc && !rd_acc: level_q <= level_q + LVL_ONE;
                rd_acc && !wr_acc: level_q <= level_q - LVL_ONE;
                default: ;
            endcase

            // A new error in the same cycle as a clear keeps the flag set.
            if (wr_rej)
                overflow <= 1'b1;
            else if (clear_errors)
                overflow <= 1'b0;

            if (rd_rej)
                underflow <= 1'b1;
            else if (clear_errors)
                underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc)
            mem[wr_ptr] <= write_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign read_data = empty ? '0 : mem[rd_ptr];
`else
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            rd_q <= '0;
        else if (rd_acc)
            rd_q <= mem[rd_ptr];
    end

    assign read_data = rd_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized scoreboard bench for sync_fifo against a queue-based reference model.
// Works in both standard and SYNC_FIFO_FWFT_EN builds.
module tb_sync_fifo;

    localparam int DW    = 4;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int AFL   = 28;
    localparam int AEL   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wi = 1'b0;
    logic          ri = 1'b0;
    logic          ce = 1'b0;
    logic [DW-1:0] wd = '0;
    logic [DW-1:0] rd;
    logic          empty;
    logic          full;
    logic          ae;
    logic          af;
    logic [AW:0]   level;
    logic          ovf;
    logic          udf;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH(DW),
        .ADDRESS_WIDTH(AW),
        .ALMOST_FULL_LEVEL(AFL),
        .ALMOST_EMPTY_LEVEL(AEL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .write_data(wd),
        .write_increment(wi),
        .read_increment(ri),
        .clear_errors(ce),
        .read_data(rd),
        .empty(empty),
        .full(full),
        .almost_empty(ae),
        .almost_full(af),
        .level(level),
        .overflow(ovf),
        .underflow(udf)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int mq[$];
    int exp_q[$];
    int m_rd   = 0;
    bit m_ovf  = 1'b0;
    bit m_udf  = 1'b0;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        int sz;
        sz = mq.size();
        chk("level", int'(level), sz);
        chk("empty", int'(empty), int'(sz == 0));
        chk("full", int'(full), int'(sz == DEPTH));
        chk("almost_empty", int'(ae), int'(sz <= AEL));
        chk("almost_full", int'(af), int'(sz >= AFL));
        chk("overflow", int'(ovf), int'(m_ovf));
        chk("underflow", int'(udf), int'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        chk("read_data", int'(rd), (sz > 0) ? mq[0] : 0);
`else
        chk("read_data", int'(rd), m_rd);
`endif
    endtask

    task automatic step(bit w, bit r, int d, bit c);
        bit wa;
        bit ra;
        int v;
        @(negedge clk);
        rst_n = 1'b1;
        wi = w;
        ri = r;
        wd = DW'(d);
        ce = c;
        wa = w && (mq.size() < DEPTH);
        ra = r && (mq.size() > 0);
        if (ra) begin
            v = mq.pop_front();
            exp_q.push_back(v);
            m_rd = v;
        end
        if (wa)
            mq.push_back(d % (1 << DW));
        if (w && !wa)
            m_ovf = 1'b1;
        else if (c)
            m_ovf = 1'b0;
        if (r && !ra)
            m_udf = 1'b1;
        else if (c)
            m_udf = 1'b0;
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wi = 1'b1;
        ri = 1'b1;
        wd = DW'(9);
        ce = 1'b0;
        mq.delete();
        m_rd  = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(posedge clk);
        #1;
        check_status();
    endtask

    // Monitor: pops the scoreboard whenever the DUT accepts a read.
    initial begin
        bit acc;
        int d;
        forever begin
            @(negedge clk);
            #4;
            acc = rst_n && ri && !empty;
            d = int'(rd);
`ifndef SYNC_FIFO_FWFT_EN
            if (acc) begin
                @(posedge clk);
                #2;
                d = int'(rd);
            end
`endif
            if (acc) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard: got %0d expected none at %0t",
                             d, $time);
                end else begin
                    chk("scoreboard", d, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int k;
        int pw;
        int pr;
        do_reset();

        for (int i = 1; i <= 15; i++)
            step(1, 0, i, 0);
        repeat (15) step(0, 1, 0, 0);

        for (int i = 0; i < DEPTH; i++)
            step(1, 0, i + 3, 0);
        step(1, 0, 14, 0);
        step(0, 1, 0, 0);
        repeat (DEPTH - 1) step(0, 1, 0, 0);
        step(0, 0, 0, 1);

        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);

        k = 0;
        repeat (5) begin
            step(1, 0, k, 0);
            k++;
        end
        repeat (100) begin
            step(1, 1, k, 0);
            k++;
        end
        repeat (5) step(0, 1, 0, 0);

        for (int i = 0; i < DEPTH; i++)
            step(1, 0, 15 - (i % 16), 0);
        step(1, 1, 5, 0);
        repeat (DEPTH - 1) step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(1, 1, 7, 0);
        step(0, 1, 0, 1);

        for (int i = 0; i < 10; i++)
            step(1, 0, i + 1, 0);
        do_reset();
        step(1, 0, 10, 0);
        step(0, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            unique case ((i / 250) % 3)
                0: begin pw = 80; pr = 30; end
                1: begin pw = 30; pr = 80; end
                default: begin pw = 60; pr = 60; end
            endcase
            if ($urandom_range(0, 199) == 0)
                do_reset();
            else
                step($urandom_range(0, 99) < pw,
                     $urandom_range(0, 99) < pr,
                     int'($urandom_range(0, 15)),
                     $urandom_range(0, 19) == 0);
        end

        repeat (3) step(0, 0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO, the next generation of the team's 4-bit FIFO block: configurable data width and depth, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. It sits behind the top-level pin wrapper, between a synchronous producer and consumer in the `clk` domain. It is intended for buffering pin-driven traffic once both sides share the system clock.

## Interface
- `DATA_WIDTH`, default 4: bits per entry.
- `ADDRESS_WIDTH`, default 5: pointer width. DEPTH = 2^ADDRESS_WIDTH (default 32).
- `ALMOST_FULL_LEVEL`, default 28: `almost_full` asserts when level >= this value. Legal range 1..DEPTH.
- `ALMOST_EMPTY_LEVEL`, default 4: `almost_empty` asserts when level <= this value. Legal range 0..DEPTH-1.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `write_data` input DATA_WIDTH: entry to push.
- `write_increment` input 1: push request.
- `read_increment` input 1: pop request.
- `clear_errors` input 1: clears `overflow` and `underflow`.
- `read_data` output DATA_WIDTH: popped or head data (mode dependent, see Configuration).
- `empty`, `full` output 1 each: level == 0 and level == DEPTH respectively.
- `almost_empty`, `almost_full` output 1 each: threshold flags.
- `level` output ADDRESS_WIDTH+1: current occupancy, 0..DEPTH.
- `overflow`, `underflow` output 1 each: sticky error flags.

## Operation
- Write accepted iff `write_increment && !full`. Read accepted iff `read_increment && !empty`. Both use flag values from before the edge.
- Accepted write: mem[wr_ptr] <= `write_data`, then wr_ptr+1. Accepted read: rd_ptr+1.
- Pointers are ADDRESS_WIDTH bits and wrap modulo DEPTH with no special case.
- Level update: +1 for a write only, -1 for a read only, unchanged for both or neither.
- Simultaneous read and write when 0 < level < DEPTH: both are accepted and level is unchanged.
- Simultaneous request at full: the read is accepted, the write is dropped, `overflow` sets, and level goes to DEPTH-1.
- Simultaneous request at empty: the write is accepted, the read is rejected, `underflow` sets, and level goes to 1.
- Rejected write (request while full): data is discarded, `overflow` <= 1, no other state changes.
- Rejected read (request while empty): `underflow` <= 1, and pointers and `read_data` are unchanged.
- Sticky flags clear only on `clear_errors` or reset. If `clear_errors` and a new error occur in the same cycle, set wins.
- All four status flags are combinational decodes of the registered level; there is no separate flag state.
- There is no state machine beyond pointers, level and flags.

## Timing
- Reset values: `level`=0, `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `overflow`=0, `underflow`=0, `read_data`=0, both pointers=0. Memory contents are not reset.
- Reset mid-operation discards all contents on the first `clk` edge with `rst_n`=0. Requests in reset cycles are ignored and do not set error flags.
- Write at edge N: `level`, `empty`, `full` and the almost flags reflect it immediately after edge N. The entry can be popped by a read request in cycle N+1.
- Standard mode: read accepted at edge N gives `read_data` valid after edge N (1-cycle latency). It holds until the next accepted read.
- Throughput is one push and one pop per cycle, sustained.

## Configuration
- `SYNC_FIFO_FWFT_EN` defined: first-word-fall-through.
  - `read_data` = mem[rd_ptr] combinationally while `!empty`, and 0 while `empty`.
  - An accepted read advances to the next head after the edge.
  - A write into an empty FIFO appears on `read_data` immediately after the write edge.
- `SYNC_FIFO_FWFT_EN` undefined: standard registered-output mode as described in Timing.
- All flag, level and error behaviour is identical in both modes.

## Test plan
- Reset, then push 0x1..0xF (15 writes, no reads). Required: `level`=15, `empty`=0, `almost_empty`=0. Then pop 15 and check `read_data` sequence 0x1..0xF with correct per-mode latency.
- Fill to 32: `almost_full` asserts at level 28, `full` at 32. A 33rd write gives `overflow`=1, `level` stays 32, and a later read returns the first entry, not the dropped one.
- Pop from empty: `underflow`=1, `read_data` unchanged, `level`=0. Assert `clear_errors` in the same cycle as a new underflow: flag stays 1. `clear_errors` alone clears it.
- Continuous simultaneous push/pop for 100 cycles at level 5 with an incrementing pattern. Required: `level` constant at 5, pointers wrap past 31 at least three times, data order is preserved.
- At full, assert read and write together: `overflow`=1, `level`=31. At empty, assert both: `underflow`=1, `level`=1, and the written value is read back next.
- Load 10 entries, then drive `rst_n`=0 for 1 cycle. Required: all outputs at reset values. A subsequent write/read of 0xA returns 0xA.
